// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the round-robin valid/data mux.
// Default channel count, data width, clog2 helper and pointer reset value.
package mux_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // Pointer resets to the last channel so channel 0 is searched first.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around round-robin search over NUM_CH requests, one-hot plus encoded grant.
// MUX_RR_STRICT_PRIO_EN selects fixed lowest-index-wins priority instead.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_vec,
  input  logic [CH_W-1:0]   last_grant,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic            found;
  logic [CH_W-1:0] win_idx;

`ifdef MUX_RR_STRICT_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        found   = 1'b1;
        win_idx = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] cand;

  // Scan from farthest to nearest so the closest requester after the pointer wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (CH_W + 1)'(k);
      if (sum >= (CH_W + 1)'(NUM_CH)) begin
        sum = sum - (CH_W + 1)'(NUM_CH);
      end
      cand = sum[CH_W-1:0];
      if (req_vec[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  assign grant_idx = win_idx;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign grant[gi] = enable && found && (win_idx == CH_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux_rr.sv
// N-channel registered valid/data mux with round-robin arbitration, pause and pop.
// Build option MUX_RR_STRICT_PRIO_EN switches the arbiter to strict priority.
module mux_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  input  logic                     pause,
  output logic [NUM_CH-1:0]        pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [CH_W-1:0]          grant_id
);

  localparam logic [CH_W-1:0] LAST_RST = CH_W'(ptr_reset(NUM_CH));

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic              req;
  logic [CH_W-1:0]   win_idx;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_q, last_d;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign req = !pause && (|valid_in);

  // Gating with reset_L keeps pop low for the whole time reset is held.
  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req_vec    (valid_in),
    .last_grant (last_q),
    .enable     (!pause && reset_L),
    .grant      (pop),
    .grant_idx  (win_idx)
  );

  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (req) begin
      valid_d = 1'b1;
      data_d  = ch_data[win_idx];
      grant_d = win_idx;
      last_d  = win_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign grant_id  = grant_q;

endmodule

// File: doc/mux_rr.md
Name: mux_rr

Overview:
- N-channel, parametrised successor of the 2:1 registered valid/data mux.
- Replaces the external selector with an internal round-robin arbiter over N input channels. Each channel is the head of a show-ahead FIFO.
- Adds downstream backpressure (pause) and a pop strobe to the upstream FIFOs.
- Sits between the per-VC/TC FIFOs and the next-stage FIFO on the PCIe QoS datapath. Registered output, 1-cycle latency.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 6, data width per channel.
- CH_W, $clog2(NUM_CH), width of the channel index (derived; do not override).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_L  input  1  asynchronous active-low reset; assertion clears state immediately, release is synchronous to clk upstream.
- data_in  input  NUM_CH*DATA_W  flattened channel data; channel i at [i*DATA_W +: DATA_W].
- valid_in  input  NUM_CH  channel i head data valid (FIFO not empty).
- pause  input  1  downstream almost-full; 1 = no grant this cycle.
- pop  output  NUM_CH  combinational one-hot (or zero) read strobe to upstream FIFO i.
- data_out  output  DATA_W  registered data of the granted channel.
- valid_out  output  1  registered; 1 = data_out carries a new word this cycle.
- grant_id  output  CH_W  registered index of the channel that produced data_out.

Behaviour:
- Reset (reset_L=0, asynchronous): valid_out=0, data_out=0, grant_id=0, last_grant=NUM_CH-1, so channel 0 has first priority after reset. pop=0 while reset_L=0.
- Arbitration (combinational):
  - Search starts at (last_grant+1) mod NUM_CH and wraps to index 0 after NUM_CH-1.
  - The first i with valid_in[i]=1 is the winner g.
  - req = !pause && |valid_in.
  - pop[g]=req; all other pop bits are 0.
- Update on rising edge with reset_L=1:
  - If req: data_out<=data_in[g], valid_out<=1, grant_id<=g, last_grant<=g.
  - Else: valid_out<=0; data_out, grant_id and last_grant hold.
- Latency: data selected in cycle t appears at data_out with valid_out=1 in cycle t+1. Sustained throughput is 1 word/cycle.
- Fairness: with all channels continuously valid, grants follow 0,1,…,NUM_CH-1,0,… No channel waits more than NUM_CH-1 grants.
- Single valid channel: granted every cycle (back-to-back allowed).
- pause=1: pop=0 and no grant; valid_out drops to 0 on the next edge. The pointer does not advance, so the same channel wins on resume if still valid.
- valid_in changing while pause=1: no effect on state.
- Mid-operation reset: all outputs return to reset values immediately. No pop is issued while reset is asserted; there are no partial transfers.
- Non-power-of-two NUM_CH: the pointer wraps at NUM_CH-1, never at 2^CH_W-1.
- valid_in=0 on all channels: pop=0, valid_out<=0, pointer holds.

Optional Feature:
- MUX_RR_STRICT_PRIO_EN defined: the arbiter is strict priority. The lowest index with valid_in=1 always wins; last_grant is not used for selection but is still updated.
- Undefined (default): round-robin as above.
- Reset values and the ports are identical in both builds.

Decomposition:
- Shared header/package mux_pkg:
  - default NUM_CH and DATA_W
  - clog2 helper
  - reset value of the pointer (NUM_CH-1)
- One natural sub-module, rr_arbiter (NUM_CH):
  - inputs: req vector, last_grant, enable
  - outputs: one-hot grant and encoded index
  - holds the wrap-around search and the MUX_RR_STRICT_PRIO_EN variant
- mux_rr holds the data muxing, output registers and last_grant register.

Test Plan:
- Reset: reset_L=0 with valid_in=4'b1111 → pop=0, valid_out=0, data_out=0, grant_id=0. After release, the first grant goes to channel 0.
- Round-robin: NUM_CH=4, valid_in=4'b1111, channel i data=i+10, pause=0 for 8 cycles → data_out 10,11,12,13,10,11,12,13 from cycle t+1, valid_out=1 throughout, one-hot pop each cycle.
- Sparse/wrap: last grant=3, valid_in=4'b0101 → grants ch0, ch2, ch0; a grant to ch3 is never issued while valid_in[3]=0.
- Backpressure: all valid, assert pause for 3 cycles after a grant to ch1 → pop=0 and valid_out=0 for 3 cycles. On release, ch2 is granted next.
- Async reset mid-stream: drop reset_L between clock edges during a burst → valid_out=0 and grant_id=0 immediately. After release, a grant to ch0 comes first.
- Strict priority build (MUX_RR_STRICT_PRIO_EN), valid_in=4'b1010 for 4 cycles → ch1 granted every cycle and ch3 never.
